// File: rtl/demux1_4_buf.sv
// 1:4 demultiplexer with a registered one-entry buffer per output channel.
// Latency 1 cycle Data->Out; in_ready drops only when the selected channel is full and not draining.
module demux1_4_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Data,
    input  logic [1:0]       Select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Out0,
    output logic [WIDTH-1:0] Out1,
    output logic [WIDTH-1:0] Out2,
    output logic [WIDTH-1:0] Out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] xfer_count
);

    logic [WIDTH-1:0] r_out [4];
    logic [3:0]       r_vld;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;

    // A full channel can still take a word in the same cycle it is being drained.
    assign in_ready = ~r_vld[Select] | out_ready[Select];
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_out[i] <= '0;
            end
            r_vld <= '0;
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_accept && (Select == 2'(i))) begin
                    r_out[i] <= Data;
                    r_vld[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    r_vld[i] <= 1'b0;
                end
            end
            if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign Out0       = r_out[0];
    assign Out1       = r_out[1];
    assign Out2       = r_out[2];
    assign Out3       = r_out[3];
    assign out_valid  = r_vld;
    assign xfer_count = r_cnt;

endmodule

// File: tb/tb_demux1_4_buf.sv
// Randomized and directed bench for demux1_4_buf against a word-level model of the four buffers.
module tb_demux1_4_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Data = '0;
    logic [1:0]  Select = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Out0, Out1, Out2, Out3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [7:0]  xfer_count;

    integer checks = 0;
    integer failures = 0;

    demux1_4_buf #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .Data(Data), .Select(Select),
        .in_valid(in_valid), .in_ready(in_ready),
        .Out0(Out0), .Out1(Out1), .Out2(Out2), .Out3(Out3),
        .out_valid(out_valid), .out_ready(out_ready), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    logic [31:0] dout [4];
    assign dout[0] = Out0;
    assign dout[1] = Out1;
    assign dout[2] = Out2;
    assign dout[3] = Out3;

    // Model: each channel holds at most one word; count accepted words.
    logic [31:0] m_word [4];
    bit          m_full [4];
    int          m_count;

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_word[i] = '0;
            m_full[i] = 0;
        end
        m_count = 0;
    end

    function automatic bit m_ready(input logic [1:0] sel, input logic [3:0] ord);
        return !m_full[sel] || ord[sel];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_word[i] = '0;
                m_full[i] = 0;
            end
            m_count = 0;
        end else begin
            bit acc;
            acc = in_valid && m_ready(Select, out_ready);
            for (int i = 0; i < 4; i++) begin
                bit delivered;
                bit loaded;
                delivered = m_full[i] && out_ready[i];
                loaded    = acc && (int'(Select) == i);
                m_full[i] = (m_full[i] && !delivered) || loaded;
                if (loaded) m_word[i] = Data;
            end
            if (acc) m_count = (m_count + 1) % 256;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            logic [3:0] ev;
            for (int i = 0; i < 4; i++) begin
                ev[i] = m_full[i];
                chk($sformatf("model_out%0d", i), dout[i], m_word[i]);
            end
            chk("model_out_valid", 32'(out_valid), 32'(ev));
            chk("model_xfer_count", 32'(xfer_count), 32'(m_count));
            chk("model_in_ready", 32'(in_ready), 32'(m_ready(Select, out_ready)));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] words [4];
    logic [31:0] prev;

    initial begin
        words[0] = 32'hF0F0F0F0;
        words[1] = 32'hF8F8F8F8;
        words[2] = 32'hFBFBFBFB;
        words[3] = 32'hFFFFFFFF;

        // Reset then idle
        #1 reset = 1'b1;
        #1;
        chk("rst_out0", Out0, 32'h0);
        chk("rst_out1", Out1, 32'h0);
        chk("rst_out2", Out2, 32'h0);
        chk("rst_out3", Out3, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(xfer_count), 32'h0);
        for (int s = 0; s < 4; s++) begin
            Select = 2'(s);
            #1;
            chk($sformatf("rst_in_ready_sel%0d", s), 32'(in_ready), 32'h1);
        end
        step();
        step();
        reset = 1'b0;

        // Route all four with consumers stalled
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            Data   = words[k];
            Select = 2'(k);
            step();
            chk($sformatf("route_out%0d", k), dout[k], words[k]);
        end
        in_valid = 1'b0;
        chk("route_valid", 32'(out_valid), 32'hF);
        chk("route_count", 32'(xfer_count), 32'd4);

        // Backpressure on channel 2
        Data = 32'h12345678;
        Select = 2'd2;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready_low", 32'(in_ready), 32'h0);
            step();
            chk("bp_out2_held", Out2, 32'hFBFBFBFB);
        end
        out_ready = 4'b0100;
        #1;
        chk("bp_in_ready_high", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        out_ready = 4'b0000;
        chk("bp_out2_new", Out2, 32'h12345678);
        chk("bp_valid2", 32'(out_valid[2]), 32'h1);
        chk("bp_count", 32'(xfer_count), 32'd5);

        // Drain channels 0 and 2
        out_ready = 4'b0101;
        step();
        out_ready = 4'b0000;
        chk("drain_valid", 32'(out_valid), 32'hA);
        chk("drain_out0_kept", Out0, 32'hF0F0F0F0);
        chk("drain_out2_kept", Out2, 32'h12345678);

        // Streaming into channel 1
        out_ready = 4'b0010;
        Select = 2'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            Data = $urandom;
            prev = Data;
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'h1);
            step();
            chk("stream_out1", Out1, prev);
        end
        in_valid = 1'b0;
        chk("stream_count", 32'(xfer_count), 32'd105);

        // Random traffic, checked by the model every cycle
        for (int k = 0; k < 400; k++) begin
            Data      = $urandom;
            Select    = 2'($urandom_range(0, 3));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 4'($urandom_range(0, 15));
            step();
        end

        // Async reset between edges with channels 0 and 1 full
        in_valid = 1'b0;
        out_ready = 4'hF;
        step();
        out_ready = 4'h0;
        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            Select = 2'(k);
            Data = 32'hA5A50000 + 32'(k);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'h3);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_out0", Out0, 32'h0);
        chk("async_rst_out1", Out1, 32'h0);
        chk("async_rst_count", 32'(xfer_count), 32'h0);
        step();
        chk("rst_hold_valid", 32'(out_valid), 32'h0);
        reset = 1'b0;

        // Counter wrap
        out_ready = 4'hF;
        in_valid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            Select = 2'($urandom_range(0, 3));
            Data = $urandom;
            step();
            if (k == 254) chk("wrap_count_255", 32'(xfer_count), 32'd255);
        end
        in_valid = 1'b0;
        chk("wrap_count_0", 32'(xfer_count), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux1_4_buf.md
Name: demux1_4_buf

Overview:
- 1-to-4 demultiplexer with a registered one-entry buffer on each output channel. It is the distribution counterpart of the 4:1 32-bit output selector.
- Routes one 32-bit input word to the channel given by Select, using a valid/ready handshake on the input side and on every output channel.
- Used wherever a single producer (e.g. ALU result or write-back bus) feeds one of four consumers (e.g. register bank lanes), and a consumer may stall.

Parameters:
- WIDTH, 32, data width of Data and Out0..Out3
- CNT_W, 8, width of the accepted-transfer counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Data  input  WIDTH  input word
- Select  input  2  destination channel, 2'b00..2'b11 maps to Out0..Out3
- in_valid  input  1  Data/Select valid this cycle
- in_ready  output  1  block can accept Data this cycle (combinational)
- Out0, Out1, Out2, Out3  output  WIDTH  registered channel data
- out_valid  output  4  bit i: Out_i holds an undelivered word
- out_ready  input  4  bit i: consumer i takes Out_i this cycle
- xfer_count  output  CNT_W  number of accepted input words, modulo 2^CNT_W

Behaviour:
- Reset, asynchronous and active-high:
  - Out0..Out3 = 0, out_valid = 4'b0000, xfer_count = 0.
  - Reset asserted mid-operation discards all buffered words immediately; no delivery occurs after reset.
- Channel buffer state per channel i:
  - EMPTY (out_valid[i]=0) and FULL (out_valid[i]=1).
  - There is no other state; the block has no global FSM.
- Ready:
  - in_ready = ~out_valid[Select] | out_ready[Select].
  - Purely combinational from Select, out_valid and out_ready; it does not depend on in_valid.
  - in_ready for one channel is unaffected by the full/empty state of the other channels.
- Accept: accept = in_valid & in_ready, sampled on the rising edge of clk.
  - On accept: Out_Select <= Data, out_valid[Select] <= 1, xfer_count <= xfer_count + 1.
  - The counter wraps from 2^CNT_W-1 to 0.
- Latency: a word accepted at edge N is visible on Out_Select with out_valid high immediately after edge N. That is 1 cycle input-to-output, with no combinational path from Data to Out.
- Drain: if out_valid[i] & out_ready[i] at an edge and channel i is not loaded at that edge, then out_valid[i] <= 0.
  - Out_i keeps its last value after drain; data is not cleared.
- Simultaneous drain and load on the same channel: the new word is written and out_valid stays 1. This gives full throughput, one word per cycle, per channel.
- Simultaneous drain of channel j and load of channel i (i != j): both actions take effect independently.
- Multiple channels may drain in the same cycle.
- Stall: when channel Select is FULL and out_ready[Select]=0, in_ready=0 and nothing is written. Data, Select and in_valid must be held by the producer; the block does not latch them.
- out_ready[i] asserted while out_valid[i]=0 has no effect.
- Select is ignored when in_valid=0, apart from driving in_ready.
- Out_i and out_valid[i] are never modified by a transfer addressed to another channel.

Test Plan:
- Reset then idle: assert reset with clk running -> Out0..3=0, out_valid=0000, xfer_count=0, in_ready=1 for every Select.
- Route all four: with out_ready=0000, send F0F0F0F0/00, F8F8F8F8/01, FBFBFBFB/10, FFFFFFFF/11 on consecutive cycles -> Out0..3 hold those words one cycle after each accept, out_valid=1111, xfer_count=4.
- Backpressure: channel 2 FULL with out_ready[2]=0, present 12345678/10 -> in_ready=0 for 3 cycles, Out2 stays FBFBFBFB. Then raise out_ready[2] -> word accepted that cycle, Out2=12345678 next cycle, out_valid[2] stays 1.
- Drain: out_valid=1111, pulse out_ready=0101 for one cycle with in_valid=0 -> out_valid=1010, Out0 and Out2 keep their values.
- Streaming: out_ready[1]=1, send 100 words to Select=01 back-to-back -> in_ready held 1, one word per cycle, Out1 tracks the input with 1-cycle delay.
- Counter wrap and async reset: accept 256 words -> xfer_count=0. Assert reset between clock edges while out_valid=0011 -> outputs clear immediately, with no clock edge needed.
